// File: rtl/io_poll_master.sv
// Autonomous bus initiator for the switch/LED IO responder: polls status, reads the
// switch bytes when ready, and writes a mode-dependent 12-bit LED value.
module io_poll_master #(
    parameter int POLL_INTERVAL = 16,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        pRead,
    output logic        pWrite,
    output logic [1:0]  addr,
    output logic [11:0] pWriteData,
    input  logic [31:0] pReadData,
    output logic [15:0] switch_val,
    output logic [11:0] led_val,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_STAT,
        ST_RD_HI,
        ST_RD_LO,
        ST_WR_LED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);

    state_t          state;
    state_t          next_state;
    state_t          end_state;
    logic [CNT_W-1:0] counter;
    logic [7:0]      hi;
    logic            have_val;
    logic [15:0]     new_sw;
    logic            is_dup;
    logic [11:0]     led_calc;
    logic            rd_next;
    logic            wr_next;
    logic [1:0]      addr_next;
    logic            unused_rd_bits;

    assign unused_rd_bits = ^pReadData[31:8];
    assign busy           = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        addr_next  = 2'b00;
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        new_sw     = {hi, pReadData[7:0]};
        is_dup     = have_val && (new_sw == switch_val);
        end_state  = enable ? ST_WAIT : ST_IDLE;

        case (mode)
            2'b00:   led_calc = new_sw[11:0];
            2'b01:   led_calc = {3'b000, {1'b0, hi} + {1'b0, pReadData[7:0]}};
            2'b10:   led_calc = {4'h0, hi ^ pReadData[7:0]};
            default: led_calc = {4'h0, hi & ~pReadData[7:0]};
        endcase

        case (state)
            ST_IDLE:    if (enable) next_state = ST_WAIT;
            ST_WAIT: begin
                if (!enable)                next_state = ST_IDLE;
                else if (counter == CNT_LAST) next_state = ST_RD_STAT;
            end
            ST_RD_STAT: next_state = pReadData[1] ? ST_RD_HI : end_state;
            ST_RD_HI:   next_state = ST_RD_LO;
            ST_RD_LO:   next_state = is_dup ? end_state : ST_WR_LED;
            ST_WR_LED:  next_state = end_state;
            default:    next_state = ST_IDLE;
        endcase

        // Strobes and address are registered, so decode them from the state being entered.
        case (next_state)
            ST_RD_STAT: begin rd_next = 1'b1; addr_next = 2'b00; end
            ST_RD_HI:   begin rd_next = 1'b1; addr_next = 2'b11; end
            ST_RD_LO:   begin rd_next = 1'b1; addr_next = 2'b10; end
            ST_WR_LED:  begin wr_next = 1'b1; addr_next = 2'b01; end
            default:    ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            counter    <= '0;
            pRead      <= 1'b0;
            pWrite     <= 1'b0;
            addr       <= 2'b00;
            pWriteData <= '0;
            switch_val <= '0;
            led_val    <= '0;
            done       <= 1'b0;
            have_val   <= 1'b0;
            hi         <= '0;
        end else begin
            state   <= next_state;
            counter <= (state == ST_WAIT && next_state == ST_WAIT) ? counter + CNT_W'(1) : '0;
            pRead   <= rd_next;
            pWrite  <= wr_next;
            addr    <= addr_next;
            done    <= (state == ST_WR_LED);

            if (state == ST_RD_HI) hi <= pReadData[7:0];

            if (state == ST_RD_LO && !is_dup) begin
                switch_val <= new_sw;
                pWriteData <= led_calc;
            end

            if (state == ST_WR_LED) begin
                led_val  <= pWriteData;
                have_val <= 1'b1;
            end
        end
    end

endmodule
